// File: rtl/alu_seq_ctrl.sv
// Command sequencer in front of the 8-bit ALU: queues {A, B, sel} commands,
// issues them one at a time and returns the ALU's result over a valid/ready response port.
module alu_seq_ctrl #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [7:0]    cmd_a,
    input  logic [7:0]    cmd_b,
    input  logic [3:0]    cmd_sel,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [3:0]    alu_sel,
    input  logic [8:0]    alu_result,
    input  logic          alu_c_out,
    input  logic          alu_over_flow,
    input  logic          alu_zero,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [8:0]    rsp_result,
    output logic [2:0]    rsp_flags,
    output logic          rsp_err,
    output logic          busy,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_CAPT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    // Bit n set means opcode n is executable by the ALU.
    localparam logic [15:0] LEGAL_MASK = 16'b1111_1111_0000_1011;

    logic [19:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [7:0]    alu_a_q, alu_a_d;
    logic [7:0]    alu_b_q, alu_b_d;
    logic [3:0]    alu_sel_q, alu_sel_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [8:0]    rsp_result_q, rsp_result_d;
    logic [2:0]    rsp_flags_q, rsp_flags_d;
    logic          rsp_err_q, rsp_err_d;

    logic          push;
    logic          pop;
    logic [19:0]   head;
    logic          head_legal;

    // Full means not ready, even if the FSM pops this cycle: no pass-through.
    assign cmd_ready  = (count_q < CW'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state_q == S_IDLE) && (count_q != '0);
    assign head       = mem_q[rd_ptr_q];
    assign head_legal = LEGAL_MASK[head[3:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_a, cmd_b, cmd_sel};
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    if (head_legal) begin
                        alu_a_d   = head[19:12];
                        alu_b_d   = head[11:4];
                        alu_sel_d = head[3:0];
                        state_d   = S_EXEC;
                    end else begin
                        // Rejected without touching the ALU operands.
                        rsp_err_d    = 1'b1;
                        rsp_result_d = '0;
                        rsp_flags_d  = '0;
                        rsp_valid_d  = 1'b1;
                        state_d      = S_RESP;
                    end
                end
            end
            S_EXEC: state_d = S_CAPT;
            S_CAPT: begin
                rsp_result_d = alu_result;
                rsp_flags_d  = {alu_c_out, alu_over_flow, alu_zero};
                rsp_err_d    = 1'b0;
                rsp_valid_d  = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;
    assign count      = count_q;
    assign busy       = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: directed commands push hand-computed responses,
// a monitor pops and compares on every accepted response.
module tb_alu_seq_ctrl;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [7:0]    cmd_a = '0;
    logic [7:0]    cmd_b = '0;
    logic [3:0]    cmd_sel = '0;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic [3:0]    alu_sel;
    logic [8:0]    alu_result = '0;
    logic          alu_c_out = 1'b0;
    logic          alu_over_flow = 1'b0;
    logic          alu_zero = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [8:0]    rsp_result;
    logic [2:0]    rsp_flags;
    logic          rsp_err;
    logic          busy;
    logic [CW-1:0] count;

    int checks    = 0;
    int failures  = 0;
    int rsp_count = 0;
    int cyc       = 0;

    logic [12:0] sb_q [$];     // {err, flags, result}
    int          load_q [$];
    logic [19:0] prev_alu = '0;

    logic [7:0] full_a   [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [8:0] full_res [5] = '{9'h012, 9'h023, 9'h034, 9'h045, 9'h056};
    logic [7:0] sim_a    [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [8:0] sim_res  [4] = '{9'h003, 9'h004, 9'h005, 9'h006};
    logic [7:0] rst_a    [5] = '{8'h05, 8'h31, 8'h32, 8'h33, 8'h34};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_c_out(alu_c_out),
        .alu_over_flow(alu_over_flow), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .busy(busy), .count(count)
    );

    // Registered ALU stand-in covering the opcodes used here (ADD, AND, OR).
    logic [8:0] add_sum;
    assign add_sum = {1'b0, alu_a} + {1'b0, alu_b};
    always @(posedge clk) begin
        case (alu_sel)
            4'b0000: begin
                alu_result    <= add_sum;
                alu_c_out     <= add_sum[8];
                alu_over_flow <= (alu_a[7] == alu_b[7]) && (add_sum[7] != alu_a[7]);
                alu_zero      <= (add_sum[7:0] == 8'h00);
            end
            4'b1000: begin
                alu_result    <= {1'b0, alu_a & alu_b};
                alu_c_out     <= 1'b0;
                alu_over_flow <= 1'b0;
                alu_zero      <= ((alu_a & alu_b) == 8'h00);
            end
            4'b1010: begin
                alu_result    <= {1'b0, alu_a | alu_b};
                alu_c_out     <= 1'b0;
                alu_over_flow <= 1'b0;
                alu_zero      <= ((alu_a | alu_b) == 8'h00);
            end
            default: begin
                alu_result    <= '0;
                alu_c_out     <= 1'b0;
                alu_over_flow <= 1'b0;
                alu_zero      <= 1'b0;
            end
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every accepted response is compared against the scoreboard head.
    initial begin
        logic [12:0] exp;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                rsp_count++;
                $display("rsp %0d: result=0x%03h flags=%03b err=%0b", rsp_count, rsp_result, rsp_flags, rsp_err);
                if (sb_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(sb_q.size()), 32'd1);
                end else begin
                    exp = sb_q.pop_front();
                    chk("rsp_data", 32'({rsp_err, rsp_flags, rsp_result}), 32'(exp));
                end
            end
        end
    end

    // Records the cycle of every change on the ALU operand/select outputs.
    initial begin
        forever begin
            @(negedge clk);
            if ({alu_a, alu_b, alu_sel} !== prev_alu) load_q.push_back(cyc);
            prev_alu = {alu_a, alu_b, alu_sel};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "time limit");
    end

    // Offers one command starting at posedge+1; returns at posedge+1 after acceptance.
    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                            input bit track, input logic [12:0] exp);
        bit accepted;
        accepted  = 1'b0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (accepted && track) sb_q.push_back(exp);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        $display("cmd a=0x%02h b=0x%02h sel=%04b accepted=%0b", a, b, sel, accepted);
        chk("cmd_accept", 32'(accepted), 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!busy && !rsp_valid && sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_done", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp", 32'({rsp_err, rsp_flags, rsp_result}), 32'd0);
        chk("rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        @(posedge clk);
        #1;

        // ADD 0x7F + 0x01 with latency checks
        rsp_ready = 1'b1;
        push_cmd(8'h7F, 8'h01, 4'b0000, 1'b1, {1'b0, 3'b010, 9'h080});
        @(negedge clk);
        chk("add_count_e0", 32'(count), 32'd1);
        chk("add_not_issued", 32'(alu_a), 32'h00);
        @(negedge clk);
        chk("add_alu_e1", 32'({alu_a, alu_b, alu_sel}), 32'({8'h7F, 8'h01, 4'b0000}));
        chk("add_no_rsp_e1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("add_no_rsp_e2", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("add_rsp_e3", 32'(rsp_valid), 32'd1);
        wait_idle();

        // AND then OR back-to-back
        load_q.delete();
        push_cmd(8'hF0, 8'h0F, 4'b1000, 1'b1, {1'b0, 3'b001, 9'h000});
        push_cmd(8'hA0, 8'h05, 4'b1010, 1'b1, {1'b0, 3'b000, 9'h0A5});
        wait_idle();
        chk("andor_loads", 32'(load_q.size()), 32'd2);
        chk("andor_load_gap_ge4", 32'((load_q.size() >= 2) && (load_q[1] - load_q[0] >= 4)), 32'd1);

        // Illegal opcode
        push_cmd(8'h12, 8'h34, 4'b0100, 1'b1, {1'b1, 3'b000, 9'h000});
        @(negedge clk);
        chk("ill_no_rsp_e0", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("ill_rsp_e1", 32'(rsp_valid), 32'd1);
        chk("ill_rsp_data", 32'({rsp_err, rsp_flags, rsp_result}), 32'({1'b1, 3'b000, 9'h000}));
        chk("ill_alu_kept", 32'({alu_a, alu_b, alu_sel}), 32'({8'hA0, 8'h05, 4'b1010}));
        wait_idle();

        // Full / backpressure
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(full_a[i], 8'h01, 4'b0000, 1'b1, {1'b0, 3'b000, full_res[i]});
        @(negedge clk);
        chk("full_count", 32'(count), 32'd4);
        chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        cmd_a = 8'h66; cmd_b = 8'h01; cmd_sel = 4'b0000; cmd_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("full_stall_ready", 32'(cmd_ready), 32'd0);
            chk("full_stall_valid", 32'(rsp_valid), 32'd1);
            chk("full_stall_rsp", 32'({rsp_err, rsp_flags, rsp_result}), 32'({1'b0, 3'b000, 9'h012}));
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("full_count_hold", 32'(count), 32'd4);
        chk("full_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_idle();
        chk("full_drain_count", 32'(count), 32'd0);
        chk("full_drain_busy", 32'(busy), 32'd0);

        // Simultaneous push/pop at count=2
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_cmd(sim_a[i], 8'h02, 4'b0000, 1'b1, {1'b0, 3'b000, sim_res[i]});
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("sim_rsp_wait", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd_a = sim_a[3]; cmd_b = 8'h02; cmd_sel = 4'b0000; cmd_valid = 1'b1;
        sb_q.push_back({1'b0, 3'b000, sim_res[3]});
        @(negedge clk);
        chk("sim_count_before", 32'(count), 32'd2);
        chk("sim_idle_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("sim_count_after", 32'(count), 32'd2);
        wait_idle();

        // Reset during EXEC with 3 commands queued
        rsp_ready = 1'b0;
        push_cmd(rst_a[0], 8'h03, 4'b0000, 1'b1, {1'b0, 3'b000, 9'h008});
        for (int i = 1; i < 5; i++) push_cmd(rst_a[i], 8'h01, 4'b0000, 1'b0, 13'h0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rexec_count_pre", 32'(count), 32'd3);
        chk("rexec_alu_pre", 32'(alu_a), 32'h31);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rexec_count", 32'(count), 32'd0);
        chk("rexec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rexec_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        chk("rexec_busy", 32'(busy), 32'd0);
        repeat (30) @(negedge clk);
        chk("rexec_no_rsp", 32'(rsp_valid), 32'd0);

        chk("rsp_total", 32'(rsp_count), 32'd14);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
